// File: rtl/rgbw_pwm_gen.sv
// -----------------------------------------------------------------------------
// rgbw_pwm_gen
//   Four-channel (R, G, B, W) PWM generator. It sits after the prescaler.
//   The prescaler level output clk_presc is edge-detected in the clk domain.
//   Each rising edge is one tick. A shared counter advances once per tick,
//   runs from 0 to 2^CNT_W-2 and then wraps to 0, so one period is
//   2^CNT_W-1 ticks. Duty d gives exactly d high ticks per period.
//   Duty writes land in shadow registers first. They become active only at
//   the period wrap, so a duty change never glitches a running period.
//
// Ports
//   clk            system clock (same clock as the prescaler)
//   reset          asynchronous, active-low reset
//   clk_presc      prescaler level; every rising edge is one tick
//   en             1 = run; 0 = counter held at 0 and all PWM outputs low
//   duty_r/g/b/w   requested duty per channel, captured on duty_load
//   duty_load      one-clk strobe: capture all four duties into shadow
//   update_pending shadow holds values that are not yet active
//   period_start   one-clk pulse on the edge where the counter wraps to 0
//   pwm_r/g/b/w    registered PWM outputs
// -----------------------------------------------------------------------------
module rgbw_pwm_gen #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_presc,
  input  logic             en,
  input  logic [CNT_W-1:0] duty_r,
  input  logic [CNT_W-1:0] duty_g,
  input  logic [CNT_W-1:0] duty_b,
  input  logic [CNT_W-1:0] duty_w,
  input  logic             duty_load,
  output logic             update_pending,
  output logic             period_start,
  output logic             pwm_r,
  output logic             pwm_g,
  output logic             pwm_b,
  output logic             pwm_w
);

  // The last count value before the wrap is 2^CNT_W-2.
  localparam logic [CNT_W-1:0] CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // Channel index: 0 = R, 1 = G, 2 = B, 3 = W.
  logic [3:0][CNT_W-1:0] duty_in_s;
  logic [3:0][CNT_W-1:0] shadow_q;
  logic [3:0][CNT_W-1:0] shadow_d;
  logic [3:0][CNT_W-1:0] active_q;
  logic [3:0][CNT_W-1:0] active_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;
  logic [CNT_W-1:0]      cnt_nxt_s;
  logic [3:0]            pwm_q;
  logic [3:0]            pwm_d;
  logic                  presc_q;
  logic                  pend_q;
  logic                  pend_d;
  logic                  ps_q;
  logic                  ps_d;
  logic                  tick_s;
  logic                  wrap_s;

  assign duty_in_s = {duty_w, duty_b, duty_g, duty_r};

  // Next-state logic: tick detect, counter, shadow/active duties and PWM compare.
  always_comb begin
    tick_s    = clk_presc & ~presc_q;
    // A wrap needs en, because the counter is held at 0 while disabled.
    wrap_s    = en & tick_s & (cnt_q == CNT_LAST);
    cnt_nxt_s = wrap_s ? {CNT_W{1'b0}} : (cnt_q + CNT_ONE);

    shadow_d = shadow_q;
    active_d = active_q;
    pend_d   = pend_q;
    if (wrap_s) begin
      // If a load lands on the wrap edge, it bypasses the shadow.
      // The new duty is active for the period that starts now.
      if (duty_load) begin
        shadow_d = duty_in_s;
        active_d = duty_in_s;
      end else begin
        active_d = shadow_q;
      end
      pend_d = 1'b0;
    end else if (duty_load) begin
      shadow_d = duty_in_s;
      pend_d   = 1'b1;
    end else begin
      pend_d = pend_q;
    end

    cnt_d = cnt_q;
    pwm_d = pwm_q;
    if (!en) begin
      cnt_d = {CNT_W{1'b0}};
      pwm_d = 4'b0000;
    end else if (tick_s) begin
      cnt_d = cnt_nxt_s;
      // Compare against the post-wrap duty. A full-scale duty then stays
      // high straight across the period boundary.
      for (int i = 0; i < 4; i++) begin
        pwm_d[i] = (cnt_nxt_s < active_d[i]);
      end
    end else begin
      cnt_d = cnt_q;
    end

    ps_d = wrap_s;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q  <= 1'b0;
      cnt_q    <= {CNT_W{1'b0}};
      shadow_q <= '0;
      active_q <= '0;
      pend_q   <= 1'b0;
      ps_q     <= 1'b0;
      pwm_q    <= 4'b0000;
    end else begin
      presc_q  <= clk_presc;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      pend_q   <= pend_d;
      ps_q     <= ps_d;
      pwm_q    <= pwm_d;
    end
  end

  assign update_pending = pend_q;
  assign period_start   = ps_q;
  assign pwm_r          = pwm_q[0];
  assign pwm_g          = pwm_q[1];
  assign pwm_b          = pwm_q[2];
  assign pwm_w          = pwm_q[3];

endmodule

// File: tb/tb_rgbw_pwm_gen.sv
module tb_rgbw_pwm_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clk_presc = 1'b0;
  logic       en = 1'b0;
  logic [7:0] duty_r = 8'h00;
  logic [7:0] duty_g = 8'h00;
  logic [7:0] duty_b = 8'h00;
  logic [7:0] duty_w = 8'h00;
  logic       duty_load = 1'b0;
  logic       update_pending;
  logic       period_start;
  logic       pwm_r;
  logic       pwm_g;
  logic       pwm_b;
  logic       pwm_w;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int id;
    int r;
    int g;
    int b;
    int w;
    int n;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  rgbw_pwm_gen #(.CNT_W(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .clk_presc      (clk_presc),
    .en             (en),
    .duty_r         (duty_r),
    .duty_g         (duty_g),
    .duty_b         (duty_b),
    .duty_w         (duty_w),
    .duty_load      (duty_load),
    .update_pending (update_pending),
    .period_start   (period_start),
    .pwm_r          (pwm_r),
    .pwm_g          (pwm_g),
    .pwm_b          (pwm_b),
    .pwm_w          (pwm_w)
  );

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Prescaler stand-in. It toggles every 3 clk when running; otherwise it follows presc_force.
  bit presc_run = 1'b0;
  bit presc_force = 1'b0;
  int phase = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (presc_run) begin
        phase++;
        if (phase >= 3) begin
          phase = 0;
          clk_presc = ~clk_presc;
        end
      end else begin
        clk_presc = presc_force;
      end
    end
  end

  // Marks the clk edges that should count as ticks (rising clk_presc as seen at posedge).
  logic presc_prev_q;
  logic tb_tick_q;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_prev_q <= 1'b0;
      tb_tick_q    <= 1'b0;
    end else begin
      tb_tick_q    <= clk_presc & ~presc_prev_q;
      presc_prev_q <= clk_presc;
    end
  end

  // Per-period high-tick accumulation. A finished period is compared with the queued expectation.
  int  acc[4];
  int  acc_n = 0;
  bit  acc_valid = 1'b0;
  int  ps_cnt = 0;
  int  per_id = 0;

  task automatic finish_period();
    exp_t e;
    per_id++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk($sformatf("period%0d_r_high", e.id), acc[0], e.r);
      chk($sformatf("period%0d_g_high", e.id), acc[1], e.g);
      chk($sformatf("period%0d_b_high", e.id), acc[2], e.b);
      chk($sformatf("period%0d_w_high", e.id), acc[3], e.w);
      chk($sformatf("period%0d_ticks", e.id), acc_n, e.n);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (period_start) ps_cnt++;
      if (!reset || !en) begin
        acc_valid = 1'b0;
      end else if (tb_tick_q) begin
        if (period_start) begin
          if (acc_valid) finish_period();
          acc[0] = int'(pwm_r); acc[1] = int'(pwm_g);
          acc[2] = int'(pwm_b); acc[3] = int'(pwm_w);
          acc_n = 1;
          acc_valid = 1'b1;
        end else if (acc_valid) begin
          acc[0] += int'(pwm_r); acc[1] += int'(pwm_g);
          acc[2] += int'(pwm_b); acc[3] += int'(pwm_w);
          acc_n++;
        end
      end
    end
  end

  task automatic push_exp(input int id, input int r, input int g, input int b, input int w);
    exp_t e;
    e.id = id; e.r = r; e.g = g; e.b = b; e.w = w; e.n = 255;
    exp_q.push_back(e);
  endtask

  // Returns at negedge+1 of the next period_start. It counts ticks and whether any PWM was high.
  task automatic wait_ps(input string tag, output int ticks, output int hi);
    bit seen = 1'b0;
    ticks = 0;
    hi = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (tb_tick_q) begin
        ticks++;
        if (pwm_r | pwm_g | pwm_b | pwm_w) hi = 1;
      end
      if (period_start) begin
        seen = 1'b1;
        break;
      end
    end
    #1;
    chk({tag, "_period_start_seen"}, int'(seen), 1);
  endtask

  task automatic wait_ticks(input string tag, input int k);
    int n = 0;
    for (int i = 0; i < 2000 && n < k; i++) begin
      @(negedge clk);
      if (tb_tick_q) n++;
    end
    #1;
    chk({tag, "_ticks_reached"}, n, k);
  endtask

  // Returns at negedge+1 when the coming posedge will be a tick.
  task automatic wait_tick_ahead();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (clk_presc && !presc_prev_q) break;
    end
  endtask

  task automatic pulse_load(input logic [7:0] r, input logic [7:0] g,
                            input logic [7:0] b, input logic [7:0] w);
    duty_r = r; duty_g = g; duty_b = b; duty_w = w;
    duty_load = 1'b1;
    @(negedge clk);
    #1;
    duty_load = 1'b0;
  endtask

  int tk;
  int hi;
  int mark;

  initial begin
    // Reset state
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_pwm_r", int'(pwm_r), 0);
    chk("rst_pwm_g", int'(pwm_g), 0);
    chk("rst_pwm_b", int'(pwm_b), 0);
    chk("rst_pwm_w", int'(pwm_w), 0);
    chk("rst_pending", int'(update_pending), 0);
    chk("rst_period_start", int'(period_start), 0);

    // Test 1: duty_r = 0x80 applied at the first wrap
    reset = 1'b1;
    en = 1'b1;
    pulse_load(8'h80, 8'h00, 8'h00, 8'h00);
    chk("t1_pending_set", int'(update_pending), 1);
    presc_run = 1'b1;
    wait_ps("t1_first_wrap", tk, hi);
    chk("t1_ticks_to_wrap", tk, 255);
    chk("t1_pending_clear", int'(update_pending), 0);
    chk("t1_pwm_r_at_wrap", int'(pwm_r), 1);
    push_exp(1, 128, 0, 0, 0);

    // Test 2: G = 0, W = 0xFF for three periods
    pulse_load(8'h80, 8'h00, 8'h00, 8'hFF);
    chk("t2_pending_set", int'(update_pending), 1);
    wait_ps("t2_p2", tk, hi);
    chk("t2_pending_clear", int'(update_pending), 0);
    chk("t2_pwm_w_at_wrap", int'(pwm_w), 1);
    push_exp(2, 128, 0, 0, 255);
    push_exp(3, 128, 0, 0, 255);
    push_exp(4, 128, 0, 0, 255);
    wait_ps("t2_p3", tk, hi);
    chk("t2_pwm_w_at_wrap3", int'(pwm_w), 1);
    wait_ps("t2_p4", tk, hi);
    wait_ps("t2_p5", tk, hi);

    // Test 3: B = 0x10 active, then load 0x40 mid-period at cnt = 100
    push_exp(5, 128, 0, 0, 255);
    pulse_load(8'h80, 8'h00, 8'h10, 8'hFF);
    wait_ps("t3_p6", tk, hi);
    push_exp(6, 128, 0, 16, 255);
    mark = ps_cnt;
    wait_ticks("t3_cnt100", 100);
    pulse_load(8'h80, 8'h00, 8'h40, 8'hFF);
    chk("t3_pending_set", int'(update_pending), 1);
    chk("t3_pwm_b_cnt100", int'(pwm_b), 0);
    wait_ticks("t3_cnt200", 100);
    chk("t3_pending_held", int'(update_pending), 1);
    wait_ps("t3_p7", tk, hi);
    chk("t3_pending_clear", int'(update_pending), 0);
    push_exp(7, 128, 0, 64, 255);
    repeat (2) @(negedge clk);
    #1;
    chk("t3_one_period_start", ps_cnt - mark, 1);

    // Test 4: load on the wrap tick (cnt = 254) bypasses the shadow
    wait_ticks("t4_cnt254", 254);
    wait_tick_ahead();
    pulse_load(8'h20, 8'h00, 8'h40, 8'hFF);
    chk("t4_period_start", int'(period_start), 1);
    chk("t4_pending_low", int'(update_pending), 0);
    chk("t4_pwm_r_new", int'(pwm_r), 1);
    push_exp(8, 32, 0, 64, 255);
    wait_ps("t4_p9", tk, hi);
    push_exp(9, 32, 0, 64, 255);
    pulse_load(8'hC8, 8'h00, 8'h40, 8'hFF);

    // Test 5: asynchronous reset at cnt = 77 while pwm_r is high
    wait_ps("t5_p10", tk, hi);
    wait_ticks("t5_cnt77", 77);
    chk("t5_pwm_r_high", int'(pwm_r), 1);
    pulse_load(8'h10, 8'h00, 8'h00, 8'h00);
    chk("t5_pending_set", int'(update_pending), 1);
    #1 reset = 1'b0;
    #1;
    chk("t5_pwm_r_async_low", int'(pwm_r), 0);
    chk("t5_pwm_w_async_low", int'(pwm_w), 0);
    chk("t5_pending_async_low", int'(update_pending), 0);
    repeat (3) @(negedge clk);
    #1;
    reset = 1'b1;
    wait_ps("t5_after_reset", tk, hi);
    chk("t5_ticks_from_zero", tk, 255);
    chk("t5_all_low_active0", hi, 0);
    chk("t5_pending_lost", int'(update_pending), 0);
    push_exp(11, 0, 0, 0, 0);
    pulse_load(8'h02, 8'h00, 8'h00, 8'h00);

    // Test 6: a level held high gives one tick; then en low
    wait_ps("t6_p12", tk, hi);
    chk("t6_pwm_r_cnt0", int'(pwm_r), 1);
    presc_run = 1'b0;
    presc_force = 1'b0;
    repeat (3) @(negedge clk);
    #1 presc_force = 1'b1;
    repeat (50) @(negedge clk);
    #1;
    chk("t6_held_high_cnt1", int'(pwm_r), 1);
    presc_force = 1'b0;
    repeat (3) @(negedge clk);
    #1 presc_force = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("t6_second_edge_cnt2", int'(pwm_r), 0);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 2) begin
        duty_r = 8'h80; duty_g = 8'h00; duty_b = 8'h00; duty_w = 8'h00;
        duty_load = 1'b1;
      end else begin
        duty_load = 1'b0;
      end
      @(negedge clk);
      #1;
      chk($sformatf("t6_en0_pwm_low_%0d", i), int'(pwm_r | pwm_g | pwm_b | pwm_w), 0);
      chk($sformatf("t6_en0_ps_low_%0d", i), int'(period_start), 0);
    end
    duty_load = 1'b0;
    chk("t6_en0_load_pending", int'(update_pending), 1);
    presc_force = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    en = 1'b1;
    presc_force = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("t6_en1_first_tick_cnt1", int'(pwm_r), 1);
    presc_force = 1'b0;
    repeat (3) @(negedge clk);
    #1 presc_force = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("t6_en1_second_tick_cnt2", int'(pwm_r), 0);
    chk("t6_pending_until_wrap", int'(update_pending), 1);
    phase = 0;
    presc_run = 1'b1;
    wait_ps("t6_wrap", tk, hi);
    chk("t6_ticks_cnt2_to_wrap", tk, 253);
    chk("t6_pending_clear", int'(update_pending), 0);
    chk("t6_pwm_r_new_duty", int'(pwm_r), 1);
    push_exp(13, 128, 0, 0, 0);
    wait_ps("t6_final", tk, hi);
    repeat (2) @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
